// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: latches the decoded control bundle and operands into EX,
// detects load-use hazards, inserts bubbles, squashes on flush, and counts stall/flush events.
module id_ex_reg #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [5:0]      id_ctrl,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [3:0]      id_funct,
  input  logic            flush,
  input  logic            hold,
  output logic            ex_valid,
  output logic [5:0]      ex_ctrl,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic [3:0]      ex_funct,
  output logic            stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Control bundle bit order: {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch}
  localparam int CTRL_MEMREAD = 2;

  logic            r_valid;
  logic [5:0]      r_ctrl;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [RA_W-1:0] r_rs1;
  logic [RA_W-1:0] r_rs2;
  logic [RA_W-1:0] r_rd;
  logic [3:0]      r_funct;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_haz;
  logic w_bubble;

  // Flow control: hold is MEM's not-ready toward us (freeze everything); stall is our
  // not-ready toward IF/ID, which must keep presenting the same instruction while it is high.
  assign w_haz = r_valid & r_ctrl[CTRL_MEMREAD] & (r_rd != '0) & id_valid &
                 ((id_rs1 == r_rd) | (id_rs2 == r_rd));
  assign w_bubble = flush | w_haz;
  assign stall    = rst_n & (hold | (w_haz & ~flush));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_ctrl      <= '0;
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_funct     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!hold) begin
      // Data fields load unconditionally; a bubble is marked only by valid/ctrl.
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_funct    <= id_funct;
      if (w_bubble) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end else begin
        r_valid <= id_valid;
        r_ctrl  <= id_valid ? id_ctrl : '0;
      end
      if (flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      if (!flush && w_haz && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_valid    = r_valid;
  assign ex_ctrl     = r_ctrl;
  assign ex_pc       = r_pc;
  assign ex_rs1_data = r_rs1_data;
  assign ex_rs2_data = r_rs2_data;
  assign ex_imm      = r_imm;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign ex_rd       = r_rd;
  assign ex_funct    = r_funct;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule
